// File: rtl/vscale_hasti_arbiter_pkg.sv
// Shared HASTI widths, transfer codes and arbiter owner encodings for the
// two-master HASTI arbiter and its hold registers.
package vscale_hasti_arbiter_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_BURST_WIDTH = 3;
  localparam int HASTI_PROT_WIDTH  = 4;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_RESP_WIDTH  = 1;

  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_IDLE   = 2'b00;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_BUSY   = 2'b01;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_NONSEQ = 2'b10;
  localparam logic [HASTI_TRANS_WIDTH-1:0] HASTI_TRANS_SEQ    = 2'b11;

  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_OKAY  = 1'b0;
  localparam logic [HASTI_RESP_WIDTH-1:0] HASTI_RESP_ERROR = 1'b1;

  localparam int ARB_OWNER_WIDTH = 2;
  localparam logic [ARB_OWNER_WIDTH-1:0] ARB_OWNER_NONE = 2'd0;
  localparam logic [ARB_OWNER_WIDTH-1:0] ARB_OWNER_M0   = 2'd1;
  localparam logic [ARB_OWNER_WIDTH-1:0] ARB_OWNER_M1   = 2'd2;

  // One complete address phase as presented by a master.
  typedef struct packed {
    logic [HASTI_ADDR_WIDTH-1:0]  haddr;
    logic                         hwrite;
    logic [HASTI_SIZE_WIDTH-1:0]  hsize;
    logic [HASTI_BURST_WIDTH-1:0] hburst;
    logic                         hmastlock;
    logic [HASTI_PROT_WIDTH-1:0]  hprot;
    logic [HASTI_TRANS_WIDTH-1:0] htrans;
  } hasti_aphase_t;

  function automatic logic is_live(input logic [HASTI_TRANS_WIDTH-1:0] htrans);
    return htrans[1];
  endfunction

endpackage

// File: rtl/vscale_hasti_arbiter_hold_reg.sv
// Per-master hold register: keeps one captured address phase plus a valid
// flag until the arbiter replays it to the slave.
module vscale_hasti_hold_reg
  import vscale_hasti_arbiter_pkg::*;
(
  input  logic          hclk,
  input  logic          hresetn,
  input  logic          i_capture,
  input  logic          i_clear,
  input  hasti_aphase_t i_aphase,
  output logic          o_valid,
  output hasti_aphase_t o_aphase
);

  logic          r_valid;
  hasti_aphase_t r_aphase;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_valid <= 1'b0;
    end else if (i_capture) begin
      r_valid <= 1'b1;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end
  end

  // Payload is qualified by r_valid, so it needs no reset.
  always_ff @(posedge hclk) begin
    if (i_capture) begin
      r_aphase <= i_aphase;
    end
  end

  assign o_valid  = r_valid;
  assign o_aphase = r_aphase;

endmodule

// File: rtl/vscale_hasti_arbiter.sv
// Two-master (m0 = dmem, m1 = imem) to one-slave HASTI arbiter with replay of
// losing address phases. Define VSCALE_HASTI_ARB_RR_EN for round-robin grants.
module vscale_hasti_arbiter
  import vscale_hasti_arbiter_pkg::*;
(
  input  logic                         hclk,
  input  logic                         hresetn,

  input  logic [HASTI_ADDR_WIDTH-1:0]  m0_haddr,
  input  logic                         m0_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m0_hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] m0_hburst,
  input  logic                         m0_hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  m0_hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] m0_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m0_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m0_hrdata,
  output logic                         m0_hready,
  output logic [HASTI_RESP_WIDTH-1:0]  m0_hresp,

  input  logic [HASTI_ADDR_WIDTH-1:0]  m1_haddr,
  input  logic                         m1_hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  m1_hsize,
  input  logic [HASTI_BURST_WIDTH-1:0] m1_hburst,
  input  logic                         m1_hmastlock,
  input  logic [HASTI_PROT_WIDTH-1:0]  m1_hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] m1_htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   m1_hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   m1_hrdata,
  output logic                         m1_hready,
  output logic [HASTI_RESP_WIDTH-1:0]  m1_hresp,

  output logic [HASTI_ADDR_WIDTH-1:0]  s_haddr,
  output logic                         s_hwrite,
  output logic [HASTI_SIZE_WIDTH-1:0]  s_hsize,
  output logic [HASTI_BURST_WIDTH-1:0] s_hburst,
  output logic                         s_hmastlock,
  output logic [HASTI_PROT_WIDTH-1:0]  s_hprot,
  output logic [HASTI_TRANS_WIDTH-1:0] s_htrans,
  output logic [HASTI_BUS_WIDTH-1:0]   s_hwdata,
  input  logic [HASTI_BUS_WIDTH-1:0]   s_hrdata,
  input  logic                         s_hready,
  input  logic [HASTI_RESP_WIDTH-1:0]  s_hresp
);

  logic [ARB_OWNER_WIDTH-1:0] r_owner;
  logic [ARB_OWNER_WIDTH-1:0] r_gnt_q;
  logic                       r_lock;
`ifdef VSCALE_HASTI_ARB_RR_EN
  logic [ARB_OWNER_WIDTH-1:0] r_last;
`endif

  hasti_aphase_t              w_m0_live_ap, w_m1_live_ap;
  hasti_aphase_t              w_m0_hold_ap, w_m1_hold_ap;
  hasti_aphase_t              w_m0_src_ap,  w_m1_src_ap;
  hasti_aphase_t              w_s_ap;
  logic                       w_m0_pend, w_m1_pend;
  logic                       w_m0_live, w_m1_live;
  logic                       w_m0_hready, w_m1_hready;
  logic                       w_m0_req, w_m1_req;
  logic                       w_m0_acc, w_m1_acc;
  logic                       w_m0_capture, w_m1_capture;
  logic                       w_m0_clear, w_m1_clear;
  logic                       w_req_any;
  logic [ARB_OWNER_WIDTH-1:0] w_gnt;

  assign w_m0_live_ap = '{haddr: m0_haddr, hwrite: m0_hwrite, hsize: m0_hsize,
                          hburst: m0_hburst, hmastlock: m0_hmastlock,
                          hprot: m0_hprot, htrans: m0_htrans};
  assign w_m1_live_ap = '{haddr: m1_haddr, hwrite: m1_hwrite, hsize: m1_hsize,
                          hburst: m1_hburst, hmastlock: m1_hmastlock,
                          hprot: m1_hprot, htrans: m1_htrans};

  assign w_m0_live = is_live(m0_htrans);
  assign w_m1_live = is_live(m1_htrans);

  // A master with a pending replay is stalled until it owns the data phase.
  assign w_m0_hready = (r_owner == ARB_OWNER_M0) ? s_hready : ~w_m0_pend;
  assign w_m1_hready = (r_owner == ARB_OWNER_M1) ? s_hready : ~w_m1_pend;

  assign m0_hready = w_m0_hready;
  assign m1_hready = w_m1_hready;
  assign m0_hresp  = (r_owner == ARB_OWNER_M0) ? s_hresp : HASTI_RESP_OKAY;
  assign m1_hresp  = (r_owner == ARB_OWNER_M1) ? s_hresp : HASTI_RESP_OKAY;
  assign m0_hrdata = s_hrdata;
  assign m1_hrdata = s_hrdata;

  assign w_m0_req = w_m0_pend | (w_m0_live & w_m0_hready);
  assign w_m1_req = w_m1_pend | (w_m1_live & w_m1_hready);

  assign w_m0_src_ap = w_m0_pend ? w_m0_hold_ap : w_m0_live_ap;
  assign w_m1_src_ap = w_m1_pend ? w_m1_hold_ap : w_m1_live_ap;

  always_comb begin
    w_gnt = ARB_OWNER_NONE;
    if (r_lock) begin
      w_gnt = r_gnt_q;
    end else begin
`ifdef VSCALE_HASTI_ARB_RR_EN
      if (w_m0_req && w_m1_req) begin
        w_gnt = (r_last == ARB_OWNER_M0) ? ARB_OWNER_M1 : ARB_OWNER_M0;
      end else if (w_m0_req) begin
        w_gnt = ARB_OWNER_M0;
      end else if (w_m1_req) begin
        w_gnt = ARB_OWNER_M1;
      end
`else
      if (w_m0_req) begin
        w_gnt = ARB_OWNER_M0;
      end else if (w_m1_req) begin
        w_gnt = ARB_OWNER_M1;
      end
`endif
    end
  end

  assign w_req_any = (w_gnt != ARB_OWNER_NONE);

  always_comb begin
    w_s_ap = '0;
    if (w_gnt == ARB_OWNER_M0) begin
      w_s_ap = w_m0_src_ap;
    end else if (w_gnt == ARB_OWNER_M1) begin
      w_s_ap = w_m1_src_ap;
    end
  end

  assign s_haddr     = w_s_ap.haddr;
  assign s_hwrite    = w_s_ap.hwrite;
  assign s_hsize     = w_s_ap.hsize;
  assign s_hburst    = w_s_ap.hburst;
  assign s_hmastlock = w_s_ap.hmastlock;
  assign s_hprot     = w_s_ap.hprot;
  assign s_htrans    = w_s_ap.htrans;

  always_comb begin
    s_hwdata = '0;
    if (r_owner == ARB_OWNER_M0) begin
      s_hwdata = m0_hwdata;
    end else if (r_owner == ARB_OWNER_M1) begin
      s_hwdata = m1_hwdata;
    end
  end

  // An address the master believes accepted but the slave did not take is
  // parked in the hold register and replayed later.
  assign w_m0_acc     = (w_gnt == ARB_OWNER_M0) & s_hready;
  assign w_m1_acc     = (w_gnt == ARB_OWNER_M1) & s_hready;
  assign w_m0_capture = w_m0_live & w_m0_hready & ~w_m0_acc;
  assign w_m1_capture = w_m1_live & w_m1_hready & ~w_m1_acc;
  assign w_m0_clear   = w_m0_pend & w_m0_acc;
  assign w_m1_clear   = w_m1_pend & w_m1_acc;

  vscale_hasti_hold_reg u_hold_m0 (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .i_capture (w_m0_capture),
    .i_clear   (w_m0_clear),
    .i_aphase  (w_m0_live_ap),
    .o_valid   (w_m0_pend),
    .o_aphase  (w_m0_hold_ap)
  );

  vscale_hasti_hold_reg u_hold_m1 (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .i_capture (w_m1_capture),
    .i_clear   (w_m1_clear),
    .i_aphase  (w_m1_live_ap),
    .o_valid   (w_m1_pend),
    .o_aphase  (w_m1_hold_ap)
  );

  // Lock freezes the grant while the slave stalls so its address stays stable.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_owner <= ARB_OWNER_NONE;
      r_lock  <= 1'b0;
      r_gnt_q <= ARB_OWNER_M0;
    end else if (s_hready) begin
      r_owner <= w_gnt;
      r_lock  <= 1'b0;
    end else if (w_req_any) begin
      r_lock  <= 1'b1;
      r_gnt_q <= w_gnt;
    end
  end

`ifdef VSCALE_HASTI_ARB_RR_EN
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      r_last <= ARB_OWNER_M1;
    end else if (s_hready && w_req_any) begin
      r_last <= w_gnt;
    end
  end
`endif

endmodule
